// File: rtl/bitslam_pkg.sv
// rtl/bitslam_pkg.sv - shared types and register map for the synth bus sequencer
package bitslam_pkg;

   localparam logic [2:0] VOICE0_DIV  = 3'd0;
   localparam logic [2:0] VOICE0_TAPS = 3'd1;
   localparam logic [2:0] VOICE1_DIV  = 3'd2;
   localparam logic [2:0] VOICE1_TAPS = 3'd3;
   localparam logic [2:0] MIXER_VOL   = 3'd4;

   typedef enum logic [1:0] {
      ST_IDLE = 2'd0,
      ST_ADDR = 2'd1,
      ST_DATA = 2'd2
   } bus_state_t;

   typedef struct packed {
      logic [2:0] addr;
      logic [5:0] data;
   } reg_write_t;

   function automatic logic [5:0] addr_field(input logic [2:0] addr);
      return {3'b000, addr};
   endfunction

endpackage

// File: rtl/bitslam_wr_fifo.sv
// rtl/bitslam_wr_fifo.sv - synchronous FIFO of register writes
// Push is accepted at full when a pop happens in the same cycle.
module bitslam_wr_fifo
   import bitslam_pkg::*;
#(
   parameter int DEPTH = 4
) (
   input  logic       clk,
   input  logic       rst_n,
   input  logic       i_push,
   input  reg_write_t i_wdata,
   input  logic       i_pop,
   output reg_write_t o_rdata,
   output logic       o_full,
   output logic       o_empty
);
   localparam int AW = $clog2(DEPTH);

   reg_write_t    r_mem [DEPTH];
   logic [AW-1:0] r_wptr;
   logic [AW-1:0] r_rptr;
   logic [AW:0]   r_count;
   logic          w_push;
   logic          w_pop;

   assign o_empty = (r_count == '0);
   assign o_full  = (r_count == (AW+1)'(DEPTH));
   assign w_pop   = i_pop & ~o_empty;
   assign w_push  = i_push & (~o_full | w_pop);
   assign o_rdata = r_mem[r_rptr];

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_wptr  <= '0;
         r_rptr  <= '0;
         r_count <= '0;
      end else begin
         if (w_push) r_wptr <= r_wptr + AW'(1);
         if (w_pop)  r_rptr <= r_rptr + AW'(1);
         case ({w_push, w_pop})
            2'b10:   r_count <= r_count + (AW+1)'(1);
            2'b01:   r_count <= r_count - (AW+1)'(1);
            default: r_count <= r_count;
         endcase
      end
   end

   always_ff @(posedge clk) begin
      if (w_push) r_mem[r_wptr] <= i_wdata;
   end

endmodule

// File: rtl/bitslam_sequencer.sv
// rtl/bitslam_sequencer.sv - merges host FIFO writes and tempo pattern writes
// onto the synth's two-phase (address, then data) register bus.
module bitslam_sequencer
   import bitslam_pkg::*;
#(
   parameter int FIFO_DEPTH = 4,
   parameter int STEPS      = 8
) (
   input  logic                     clk,
   input  logic                     rst_n,
   input  logic                     host_valid,
   output logic                     host_ready,
   input  logic [2:0]               host_addr,
   input  logic [5:0]               host_data,
   input  logic                     run,
   input  logic [7:0]               step_period,
   input  logic                     pat_we,
   input  logic [$clog2(STEPS)-1:0] pat_idx,
   input  logic [9:0]               pat_wdata,
   output logic                     bus_sel,
   output logic [5:0]               bus_data,
   output logic [$clog2(STEPS)-1:0] step_idx,
   output logic                     busy,
   output logic                     overrun
);
   localparam int SW = $clog2(STEPS);

   bus_state_t  r_state;
   bus_state_t  w_state_nxt;
   logic        r_bus_sel;
   logic        w_bus_sel_nxt;
   logic [5:0]  r_bus_data;
   logic [5:0]  w_bus_data_nxt;
   reg_write_t  r_cur;
   reg_write_t  w_cur_nxt;
   logic [2:0]  r_shadow_addr;
   logic [2:0]  w_shadow_nxt;
   logic        r_shadow_valid;

   logic [7:0]  r_tick;
   logic [SW-1:0] r_step;
   logic [STEPS-1:0] r_pat_en;
   reg_write_t  r_pat_wr [STEPS];
   logic        r_pat_pend;
   reg_write_t  r_pat_req;
   logic        r_overrun;

   reg_write_t  w_host_wr;
   reg_write_t  w_fifo_head;
   logic        w_fifo_full;
   logic        w_fifo_empty;
   logic        w_push;
   logic        w_fire;
   logic        w_fire_en;
   logic        w_sel_point;
   logic        w_sel_pat;
   logic        w_sel_fifo;
   reg_write_t  w_sel_req;
   logic        w_skip;

   assign w_host_wr  = {host_addr, host_data};
   assign host_ready = ~w_fifo_full | w_sel_fifo;
   assign w_push     = host_valid & host_ready;

   bitslam_wr_fifo #(
      .DEPTH (FIFO_DEPTH)
   ) u_fifo (
      .clk     (clk),
      .rst_n   (rst_n),
      .i_push  (w_push),
      .i_wdata (w_host_wr),
      .i_pop   (w_sel_fifo),
      .o_rdata (w_fifo_head),
      .o_full  (w_fifo_full),
      .o_empty (w_fifo_empty)
   );

   // Tempo: a fire reads the table before any same-edge pat_we update lands.
   assign w_fire    = run & (r_tick == step_period);
   assign w_fire_en = w_fire & r_pat_en[r_step];

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_tick <= '0;
         r_step <= '0;
      end else if (!run) begin
         r_tick <= '0;
         r_step <= '0;
      end else if (w_fire) begin
         r_tick <= '0;
         r_step <= r_step + SW'(1);
      end else begin
         r_tick <= r_tick + 8'd1;
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_pat_en <= '0;
      end else if (pat_we) begin
         r_pat_en[pat_idx] <= pat_wdata[9];
      end
   end

   always_ff @(posedge clk) begin
      if (pat_we) r_pat_wr[pat_idx] <= reg_write_t'(pat_wdata[8:0]);
   end

   // A pending pattern write is only selectable in IDLE/DATA; a fire that
   // lands while it is still waiting replaces it and reports the loss.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_pat_pend <= 1'b0;
         r_pat_req  <= '0;
         r_overrun  <= 1'b0;
      end else begin
         r_overrun <= w_fire_en & r_pat_pend & ~w_sel_pat;
         if (w_fire_en) begin
            r_pat_pend <= 1'b1;
            r_pat_req  <= r_pat_wr[r_step];
         end else if (w_sel_pat) begin
            r_pat_pend <= 1'b0;
         end
      end
   end

   assign w_sel_point = (r_state == ST_IDLE) | (r_state == ST_DATA);
   assign w_sel_pat   = w_sel_point & r_pat_pend;
   assign w_sel_fifo  = w_sel_point & ~r_pat_pend & ~w_fifo_empty;
   assign w_sel_req   = r_pat_pend ? r_pat_req : w_fifo_head;
   assign w_skip      = r_shadow_valid & (w_sel_req.addr == r_shadow_addr);

   always_comb begin
      w_state_nxt    = r_state;
      w_bus_sel_nxt  = 1'b0;
      w_bus_data_nxt = addr_field(r_shadow_addr);
      w_cur_nxt      = r_cur;
      w_shadow_nxt   = r_shadow_addr;
      case (r_state)
         ST_ADDR: begin
            w_state_nxt    = ST_DATA;
            w_bus_sel_nxt  = 1'b1;
            w_bus_data_nxt = r_cur.data;
         end
         ST_IDLE, ST_DATA: begin
            if (w_sel_pat | w_sel_fifo) begin
               w_cur_nxt = w_sel_req;
               if (w_skip) begin
                  w_state_nxt    = ST_DATA;
                  w_bus_sel_nxt  = 1'b1;
                  w_bus_data_nxt = w_sel_req.data;
               end else begin
                  w_state_nxt    = ST_ADDR;
                  w_bus_data_nxt = addr_field(w_sel_req.addr);
                  w_shadow_nxt   = w_sel_req.addr;
               end
            end else begin
               w_state_nxt = ST_IDLE;
            end
         end
         default: begin
            w_state_nxt = ST_IDLE;
         end
      endcase
   end

   // Bus outputs are registered from the next-state decode so they line up
   // with the state they belong to.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_state        <= ST_IDLE;
         r_bus_sel      <= 1'b0;
         r_bus_data     <= '0;
         r_cur          <= '0;
         r_shadow_addr  <= '0;
         r_shadow_valid <= 1'b0;
      end else begin
         r_state        <= w_state_nxt;
         r_bus_sel      <= w_bus_sel_nxt;
         r_bus_data     <= w_bus_data_nxt;
         r_cur          <= w_cur_nxt;
         r_shadow_addr  <= w_shadow_nxt;
         r_shadow_valid <= 1'b1;
      end
   end

   assign bus_sel  = r_bus_sel;
   assign bus_data = r_bus_data;
   assign step_idx = r_step;
   assign overrun  = r_overrun;
   assign busy     = (r_state != ST_IDLE) | ~w_fifo_empty | r_pat_pend;

endmodule

// File: tb/tb_bitslam_sequencer.sv
// tb/tb_bitslam_sequencer.sv - directed vector bench for bitslam_sequencer
module tb_bitslam_sequencer;
   import bitslam_pkg::*;

   logic       clk = 1'b0;
   logic       rst_n = 1'b0;
   logic       host_valid = 1'b0;
   logic       host_ready;
   logic [2:0] host_addr = '0;
   logic [5:0] host_data = '0;
   logic       run = 1'b0;
   logic [7:0] step_period = '0;
   logic       pat_we = 1'b0;
   logic [2:0] pat_idx = '0;
   logic [9:0] pat_wdata = '0;
   logic       bus_sel;
   logic [5:0] bus_data;
   logic [2:0] step_idx;
   logic       busy;
   logic       overrun;

   bitslam_sequencer #(.FIFO_DEPTH(4), .STEPS(8)) dut (
      .clk         (clk),
      .rst_n       (rst_n),
      .host_valid  (host_valid),
      .host_ready  (host_ready),
      .host_addr   (host_addr),
      .host_data   (host_data),
      .run         (run),
      .step_period (step_period),
      .pat_we      (pat_we),
      .pat_idx     (pat_idx),
      .pat_wdata   (pat_wdata),
      .bus_sel     (bus_sel),
      .bus_data    (bus_data),
      .step_idx    (step_idx),
      .busy        (busy),
      .overrun     (overrun)
   );

   always #5 clk = ~clk;

   typedef struct {
      logic       hv;
      logic [2:0] a;
      logic [5:0] d;
      logic       sel;
      logic [5:0] bd;
      logic       busy;
      logic       rdy;
   } vec_t;

   vec_t tv [11];
   int   n_vec = 0;
   int   n_err = 0;

   // Bus monitor: models the synth's latched address and logs every data write.
   int         cyc = 0;
   logic [2:0] addr_eff = '0;
   logic [5:0] wr_data [$];
   logic [2:0] wr_addr [$];
   int         wr_cyc [$];
   int         ovr_cnt = 0;
   int         rdy_low = 0;

   always @(negedge clk) begin
      cyc++;
      if (bus_sel) begin
         wr_data.push_back(bus_data);
         wr_addr.push_back(addr_eff);
         wr_cyc.push_back(cyc);
      end else begin
         addr_eff = bus_data[2:0];
      end
      if (overrun) ovr_cnt++;
      if (!host_ready) rdy_low++;
   end

   task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
      n_vec++;
      if (act !== exp) begin
         n_err++;
         $display("FAIL %s: got 0x%0h expected 0x%0h", nm, act, exp);
      end
   endtask

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic prog(input int i, input logic [9:0] w);
      pat_we    = 1'b1;
      pat_idx   = 3'(i);
      pat_wdata = w;
      step();
      pat_we = 1'b0;
   endtask

   task automatic wait_idle(input string nm);
      int n;
      n = 0;
      @(negedge clk);
      while (busy && n < 300) begin
         @(negedge clk);
         n++;
      end
      chk(nm, 32'(busy), 32'd0);
      step();
   endtask

   task automatic host_push(input logic [2:0] a, input logic [5:0] d);
      int n;
      n = 0;
      host_valid = 1'b1;
      host_addr  = a;
      host_data  = d;
      @(negedge clk);
      while (!host_ready && n < 300) begin
         @(negedge clk);
         n++;
      end
      chk("push_accept", 32'(host_ready), 32'd1);
      step();
      host_valid = 1'b0;
   endtask

   int         base, n, hi, ovr_base, rdy_base, busy_cnt;
   logic [2:0] prev_step;
   logic       wrap;
   logic [2:0] exp_ha [5];
   logic [5:0] exp_hd [5];
   logic [2:0] ea;

   initial begin
      tv[0]  = '{1'b1, 3'd4, 6'h2A, 1'b0, 6'h00, 1'b0, 1'b1};
      tv[1]  = '{1'b0, 3'd0, 6'h00, 1'b0, 6'h00, 1'b1, 1'b1};
      tv[2]  = '{1'b0, 3'd0, 6'h00, 1'b0, 6'h04, 1'b1, 1'b1};
      tv[3]  = '{1'b0, 3'd0, 6'h00, 1'b1, 6'h2A, 1'b1, 1'b1};
      tv[4]  = '{1'b0, 3'd0, 6'h00, 1'b0, 6'h04, 1'b0, 1'b1};
      tv[5]  = '{1'b1, 3'd1, 6'h05, 1'b0, 6'h04, 1'b0, 1'b1};
      tv[6]  = '{1'b1, 3'd1, 6'h07, 1'b0, 6'h04, 1'b1, 1'b1};
      tv[7]  = '{1'b0, 3'd0, 6'h00, 1'b0, 6'h01, 1'b1, 1'b1};
      tv[8]  = '{1'b0, 3'd0, 6'h00, 1'b1, 6'h05, 1'b1, 1'b1};
      tv[9]  = '{1'b0, 3'd0, 6'h00, 1'b1, 6'h07, 1'b1, 1'b1};
      tv[10] = '{1'b0, 3'd0, 6'h00, 1'b0, 6'h01, 1'b0, 1'b1};

      exp_ha[0] = MIXER_VOL;   exp_hd[0] = 6'h21;
      exp_ha[1] = VOICE0_TAPS; exp_hd[1] = 6'h22;
      exp_ha[2] = MIXER_VOL;   exp_hd[2] = 6'h23;
      exp_ha[3] = VOICE0_TAPS; exp_hd[3] = 6'h24;
      exp_ha[4] = MIXER_VOL;   exp_hd[4] = 6'h25;

      // Reset held: bus quiet every cycle.
      repeat (3) begin
         @(negedge clk);
         chk("reset_bus", 32'({bus_sel, bus_data, busy, host_ready}), 32'h001);
      end
      rst_n = 1'b1;
      step();

      // Single host write then back-to-back same-address writes.
      for (int i = 0; i < 11; i++) begin
         host_valid = tv[i].hv;
         host_addr  = tv[i].a;
         host_data  = tv[i].d;
         @(negedge clk);
         chk($sformatf("vec%0d", i), 32'({bus_sel, bus_data, busy, host_ready}),
             32'({tv[i].sel, tv[i].bd, tv[i].busy, tv[i].rdy}));
         step();
      end
      host_valid = 1'b0;

      // Pattern playback: step i writes data i to address 0 every 4 cycles.
      for (int i = 0; i < 8; i++) prog(i, {1'b1, VOICE0_DIV, 6'(i)});
      base = wr_data.size();
      step_period = 8'd3;
      run = 1'b1;
      prev_step = step_idx;
      wrap = 1'b0;
      n = 0;
      while (wr_data.size() < base + 9 && n < 300) begin
         @(negedge clk);
         if (prev_step == 3'd7 && step_idx == 3'd0) wrap = 1'b1;
         prev_step = step_idx;
         n++;
      end
      chk("pat_count", 32'(wr_data.size() >= base + 9), 32'd1);
      chk("pat_wrap", 32'(wrap), 32'd1);
      for (int k = 0; k < 9 && base + k < wr_data.size(); k++) begin
         chk($sformatf("pat_data%0d", k), 32'(wr_data[base+k]), 32'(k % 8));
         chk($sformatf("pat_addr%0d", k), 32'(wr_addr[base+k]), 32'(VOICE0_DIV));
         if (k >= 2)
            chk($sformatf("pat_gap%0d", k), 32'(wr_cyc[base+k] - wr_cyc[base+k-1]), 32'd4);
      end
      step();
      run = 1'b0;
      step();
      step();
      chk("run_off_step", 32'(step_idx), 32'd0);
      wait_idle("pat_idle");

      // Contention: pattern fires every cycle while the FIFO fills up.
      for (int i = 0; i < 8; i++)
         prog(i, {1'b1, (i[0] ? VOICE1_TAPS : VOICE1_DIV), 6'(i)});
      base     = wr_data.size();
      ovr_base = ovr_cnt;
      rdy_base = rdy_low;
      step_period = 8'd0;
      run = 1'b1;
      repeat (3) step();
      for (int i = 0; i < 4; i++) host_push(exp_ha[i], exp_hd[i]);
      host_valid = 1'b1;
      host_addr  = exp_ha[4];
      host_data  = exp_hd[4];
      repeat (8) step();
      chk("full_ready", 32'(host_ready), 32'd0);
      chk("ready_low_seen", 32'(rdy_low > rdy_base), 32'd1);
      hi = 0;
      for (int k = base; k < wr_data.size(); k++) if (wr_data[k] >= 6'h20) hi++;
      chk("pat_wins", 32'(hi), 32'd0);
      chk("pat_writes", 32'(wr_data.size() - base > 4), 32'd1);
      run = 1'b0;
      n = 0;
      @(negedge clk);
      while (!host_ready && n < 100) begin
         @(negedge clk);
         n++;
      end
      chk("fifth_accept", 32'(host_ready), 32'd1);
      step();
      host_valid = 1'b0;
      wait_idle("cont_idle");
      chk("overrun_seen", 32'(ovr_cnt > ovr_base), 32'd1);
      hi = 0;
      for (int k = base; k < wr_data.size(); k++) begin
         if (wr_data[k] >= 6'h20) begin
            if (hi < 5) begin
               chk($sformatf("host_order%0d", hi), 32'(wr_data[k]), 32'(exp_hd[hi]));
               chk($sformatf("host_addr%0d", hi), 32'(wr_addr[k]), 32'(exp_ha[hi]));
            end
            hi++;
         end else begin
            ea = wr_data[k][0] ? VOICE1_TAPS : VOICE1_DIV;
            chk($sformatf("pat_pair%0d", k - base), 32'(wr_addr[k]), 32'(ea));
         end
      end
      chk("host_count", 32'(hi), 32'd5);

      // Reset asserted in the middle of a DATA cycle.
      host_push(VOICE0_DIV, 6'h31);
      host_push(VOICE1_DIV, 6'h32);
      host_push(MIXER_VOL, 6'h33);
      n = 0;
      @(negedge clk);
      while (!bus_sel && n < 50) begin
         @(negedge clk);
         n++;
      end
      chk("reach_data", 32'(bus_sel), 32'd1);
      rst_n = 1'b0;
      #1;
      chk("rst_bus", 32'({bus_sel, bus_data}), 32'd0);
      chk("rst_flags", 32'({busy, host_ready, overrun, step_idx}), 32'h10);
      @(posedge clk);
      @(negedge clk);
      rst_n = 1'b1;
      step();
      @(negedge clk);
      chk("post_rst_empty", 32'({busy, host_ready}), 32'h1);
      step();
      base = wr_data.size();
      busy_cnt = 0;
      step_period = 8'd0;
      run = 1'b1;
      repeat (20) begin
         @(negedge clk);
         if (busy) busy_cnt++;
      end
      step();
      run = 1'b0;
      chk("post_rst_writes", 32'(wr_data.size() - base), 32'd0);
      chk("post_rst_busy", 32'(busy_cnt), 32'd0);

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end

endmodule
